cond_stack_unit: RTL and testbench
==================================

COND_STACK_UNIT -- requirements
Module: cond_stack_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: number of entries in the saved-flags stack (legal values 1..16).
REQ-002 The block SHALL have parameter REG_OUT, default 0: 0 = PCSrc/RegWrite/MemWrite combinational; 1 = registered, one cycle later.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 PCS  input  1  decoder: instruction writes PC.
REQ-006 RegW  input  1  decoder: instruction writes register file.
REQ-007 MemW  input  1  decoder: instruction writes memory.
REQ-008 FlagW  input  2  flag write enables; [1] = N,Z group; [0] = C,V group.
REQ-009 Cond  input  4  ARMv4 condition field.
REQ-010 ALUFlags  input  4  ALU result flags {N,Z,C,V}.
REQ-011 FlagPush  input  1  save current flags onto stack.
REQ-012 FlagPop  input  1  restore flags from stack top.
REQ-013 PCSrc, RegWrite, MemWrite  output  1 each  decoder enables gated by CondEx.
REQ-014 CondEx  output  1  condition-pass for current instruction (always combinational).
REQ-015 Flags  output  4  architectural flag register {N,Z,C,V}.
REQ-016 Depth  output  $clog2(DEPTH+1)  number of valid stack entries.
REQ-017 Overflow, Underflow  output  1 each  sticky stack error flags.

Function
REQ-018 CondEx SHALL be decoded from Cond and registered Flags (never ALUFlags): EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL(1110) 1; 1111 0.
REQ-019 PCSrc=PCS&CondEx, RegWrite=RegW&CondEx, MemWrite=MemW&CondEx; with REG_OUT=1 each is registered and appears exactly one cycle after its inputs.
REQ-020 FlagW[1]&CondEx SHALL load Flags[3:2] from ALUFlags[3:2]; FlagW[0]&CondEx SHALL load Flags[1:0] from ALUFlags[1:0]; groups are independent.
REQ-021 FlagPush, FlagPop and flag writes SHALL take effect only when CondEx=1; otherwise no state changes.
REQ-022 Push (Depth<DEPTH): stack[Depth] <= Flags value before this edge; Depth increments.
REQ-023 Push when Depth==DEPTH: no write, Depth unchanged, Overflow set.
REQ-024 Pop (Depth>0): Flags <= stack top, Depth decrements.
REQ-025 Pop when Depth==0: Flags unaffected by pop, Depth unchanged, Underflow set.
REQ-026 FlagPush and FlagPop both high: no stack operation, Depth unchanged, no error flag set; flag writes still apply.
REQ-027 A valid pop and a FlagW group write in the same cycle: the popped value SHALL win for all four flags.
REQ-028 A push and a FlagW write in the same cycle: the stack receives pre-update flags; Flags takes ALUFlags per REQ-020.
REQ-029 Overflow and Underflow SHALL remain set until reset.
REQ-030 Depth SHALL never exceed DEPTH nor wrap below 0.

Reset
REQ-031 While rst=0: Flags=4'b0000, Depth=0, Overflow=0, Underflow=0, registered outputs (REG_OUT=1) =0, stack contents don't-care.
REQ-032 Reset assertion mid-operation SHALL clear state immediately, without waiting for clk; first update follows the first rising edge after rst returns high.
REQ-033 After reset with Flags=0000, CondEx SHALL follow REQ-018 (e.g. EQ=0, NE=1, AL=1).

Verification
REQ-034 Reset; FlagW=11, Cond=1110, ALUFlags=0100, one edge -> Flags=0100; next Cond=0000, PCS=1, MemW=1 -> CondEx=1, PCSrc=1, MemWrite=1 (REG_OUT=0: same cycle; REG_OUT=1: next cycle).
REQ-035 Flags=0100; Cond=0001, FlagW=11, ALUFlags=1011, RegW=1 -> CondEx=0, RegWrite=0, Flags remain 0100.
REQ-036 DEPTH=4: five AL pushes with Flags 0001,0010,0011,0100,0101 -> Depth=4, Overflow=1; four pops restore 0100,0011,0010,0001 in that order.
REQ-037 Depth=0; AL pop -> Underflow=1, Depth=0, Flags unchanged; Underflow stays 1 across further valid ops until rst=0.
REQ-038 Depth=1, top=1010; AL pop with FlagW=11, ALUFlags=0101 -> Flags=1010, Depth=0.
REQ-039 Push then assert rst=0 between edges -> Depth, Flags, Overflow, Underflow read 0 before the next edge.

Source files
------------

// File: rtl/cond_stack_unit.sv
// Conditional-execution unit with a small saved-flags stack.
// Decodes the ARMv4 condition field against the architectural flags,
// gates the decoder write enables, and lets software push/pop {N,Z,C,V}.
module cond_stack_unit #(
    parameter int DEPTH   = 4,
    parameter bit REG_OUT = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       PCS,
    input  logic                       RegW,
    input  logic                       MemW,
    input  logic [1:0]                 FlagW,
    input  logic [3:0]                 Cond,
    input  logic [3:0]                 ALUFlags,
    input  logic                       FlagPush,
    input  logic                       FlagPop,
    output logic                       PCSrc,
    output logic                       RegWrite,
    output logic                       MemWrite,
    output logic                       CondEx,
    output logic [3:0]                 Flags,
    output logic [$clog2(DEPTH+1)-1:0] Depth,
    output logic                       Overflow,
    output logic                       Underflow
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    logic          flag_n;
    logic          flag_z;
    logic          flag_c;
    logic          flag_v;
    logic          push_req;
    logic          pop_req;
    logic          push_ok;
    logic          pop_ok;
    logic          push_err;
    logic          pop_err;
    logic [AW-1:0] push_idx;
    logic [AW-1:0] pop_idx;
    logic [3:0]    stack [DEPTH];

    assign {flag_n, flag_z, flag_c, flag_v} = Flags;

    // Condition decode uses only the registered flags, never this cycle's ALU result.
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            4'b0000: CondEx = flag_z;
            4'b0001: CondEx = ~flag_z;
            4'b0010: CondEx = flag_c;
            4'b0011: CondEx = ~flag_c;
            4'b0100: CondEx = flag_n;
            4'b0101: CondEx = ~flag_n;
            4'b0110: CondEx = flag_v;
            4'b0111: CondEx = ~flag_v;
            4'b1000: CondEx = flag_c & ~flag_z;
            4'b1001: CondEx = ~flag_c | flag_z;
            4'b1010: CondEx = (flag_n == flag_v);
            4'b1011: CondEx = (flag_n != flag_v);
            4'b1100: CondEx = ~flag_z & (flag_n == flag_v);
            4'b1101: CondEx = flag_z | (flag_n != flag_v);
            4'b1110: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

    // Push and pop together cancel each other; a failed condition blocks both.
    assign push_req = CondEx & FlagPush & ~FlagPop;
    assign pop_req  = CondEx & FlagPop & ~FlagPush;
    assign push_ok  = push_req & (Depth != FULL);
    assign push_err = push_req & (Depth == FULL);
    assign pop_ok   = pop_req & (Depth != '0);
    assign pop_err  = pop_req & (Depth == '0);
    assign push_idx = AW'(Depth);
    assign pop_idx  = AW'(Depth - DW'(1));

    // Stack storage needs no reset; only entries below Depth are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            stack[push_idx] <= Flags;
        end
    end

    // Architectural flags: a valid pop overrides any group write in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Flags <= 4'b0000;
        end else if (pop_ok) begin
            Flags <= stack[pop_idx];
        end else if (CondEx) begin
            if (FlagW[1]) begin
                Flags[3:2] <= ALUFlags[3:2];
            end
            if (FlagW[0]) begin
                Flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Stack pointer and sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Depth     <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                Depth <= Depth + DW'(1);
            end else if (pop_ok) begin
                Depth <= Depth - DW'(1);
            end
            if (push_err) begin
                Overflow <= 1'b1;
            end
            if (pop_err) begin
                Underflow <= 1'b1;
            end
        end
    end

    generate
        if (REG_OUT) begin : g_reg_out
            // Registered enables appear one cycle after the instruction that produced them.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    PCSrc    <= 1'b0;
                    RegWrite <= 1'b0;
                    MemWrite <= 1'b0;
                end else begin
                    PCSrc    <= PCS & CondEx;
                    RegWrite <= RegW & CondEx;
                    MemWrite <= MemW & CondEx;
                end
            end
        end else begin : g_comb_out
            assign PCSrc    = PCS & CondEx;
            assign RegWrite = RegW & CondEx;
            assign MemWrite = MemW & CondEx;
        end
    endgenerate

endmodule

// File: tb/tb_cond_stack_unit.sv
// Testbench for cond_stack_unit: directed scenarios plus a randomized run
// checked against a queue-based behavioural model. Two instances share the
// stimulus: one with combinational enables, one with registered enables.
module tb_cond_stack_unit;

    localparam int MDEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       PCS, RegW, MemW, FlagPush, FlagPop;
    logic [1:0] FlagW;
    logic [3:0] Cond, ALUFlags;

    logic       pcsrc, regwrite, memwrite, condex, overflow, underflow;
    logic [3:0] flags;
    logic [2:0] depth;
    logic       r_pcsrc, r_regwrite, r_memwrite, r_condex, r_overflow, r_underflow;
    logic [3:0] r_flags;
    logic [2:0] r_depth;

    int checks = 0;
    int fails  = 0;

    // Behavioural model state
    logic [3:0] mflags;
    logic [3:0] mstack[$];
    logic       mover, munder;
    logic [2:0] mreg;
    logic       mpass;
    logic [2:0] nreg;
    logic [3:0] nflags;
    logic [6:0] exp_comb, got_comb;
    logic [8:0] exp_state, got_state;

    cond_stack_unit #(.DEPTH(MDEPTH), .REG_OUT(1'b0)) dut (
        .clk(clk), .rst(rst), .PCS(PCS), .RegW(RegW), .MemW(MemW), .FlagW(FlagW),
        .Cond(Cond), .ALUFlags(ALUFlags), .FlagPush(FlagPush), .FlagPop(FlagPop),
        .PCSrc(pcsrc), .RegWrite(regwrite), .MemWrite(memwrite), .CondEx(condex),
        .Flags(flags), .Depth(depth), .Overflow(overflow), .Underflow(underflow)
    );

    cond_stack_unit #(.DEPTH(MDEPTH), .REG_OUT(1'b1)) dut_r (
        .clk(clk), .rst(rst), .PCS(PCS), .RegW(RegW), .MemW(MemW), .FlagW(FlagW),
        .Cond(Cond), .ALUFlags(ALUFlags), .FlagPush(FlagPush), .FlagPop(FlagPop),
        .PCSrc(r_pcsrc), .RegWrite(r_regwrite), .MemWrite(r_memwrite), .CondEx(r_condex),
        .Flags(r_flags), .Depth(r_depth), .Overflow(r_overflow), .Underflow(r_underflow)
    );

    always #5 clk = ~clk;

    // ARM condition table written directly from the flag meanings.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input logic pcs_i, input logic regw_i, input logic memw_i,
                         input logic [1:0] fw, input logic [3:0] c, input logic [3:0] alu,
                         input logic push, input logic pop);
        PCS = pcs_i; RegW = regw_i; MemW = memw_i; FlagW = fw;
        Cond = c; ALUFlags = alu; FlagPush = push; FlagPop = pop;
    endtask

    // Advance one clock, updating the model from the instruction-level rules.
    task automatic tick();
        mpass = cond_pass(Cond, mflags);
        nreg  = {PCS & mpass, RegW & mpass, MemW & mpass};
        if (mpass) begin
            nflags = mflags;
            if (FlagW[1]) nflags[3:2] = ALUFlags[3:2];
            if (FlagW[0]) nflags[1:0] = ALUFlags[1:0];
            if (FlagPush && !FlagPop) begin
                if (mstack.size() < MDEPTH) mstack.push_back(mflags);
                else mover = 1'b1;
            end
            if (FlagPop && !FlagPush) begin
                if (mstack.size() > 0) nflags = mstack.pop_back();
                else munder = 1'b1;
            end
            mflags = nflags;
        end
        @(posedge clk);
        mreg = nreg;
        @(negedge clk);
    endtask

    task automatic model_clear();
        mflags = 4'b0000; mstack.delete(); mover = 1'b0; munder = 1'b0; mreg = 3'b000;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(0, 0, 0, 2'b00, 4'hE, 4'h0, 0, 0);
        #1;
        model_clear();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1, 1, 1, 2'b00, 4'h0, 4'h0, 0, 0);
        #2;
        model_clear();
        checks++;
        if ({flags, depth, overflow, underflow} !== 9'b0) begin
            fails++; $display("[TB] FAIL reset_state: got %b required 0", {flags, depth, overflow, underflow});
        end
        checks++;
        if ({r_pcsrc, r_regwrite, r_memwrite} !== 3'b000) begin
            fails++; $display("[TB] FAIL reset_regout: got %b required 000", {r_pcsrc, r_regwrite, r_memwrite});
        end
        checks++;
        if (condex !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_eq: got %b required 0", condex);
        end
        Cond = 4'h1; #1;
        checks++;
        if (condex !== 1'b1) begin
            fails++; $display("[TB] FAIL reset_ne: got %b required 1", condex);
        end
        Cond = 4'hE; #1;
        checks++;
        if (condex !== 1'b1) begin
            fails++; $display("[TB] FAIL reset_al: got %b required 1", condex);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_flag_write();
        do_reset();
        drive(0, 0, 0, 2'b11, 4'hE, 4'b0100, 0, 0);
        tick();
        checks++;
        if (flags !== 4'b0100) begin
            fails++; $display("[TB] FAIL write_flags: got %b required 0100", flags);
        end
        drive(1, 0, 1, 2'b00, 4'h0, 4'h0, 0, 0);
        #1;
        checks++;
        if ({condex, pcsrc, regwrite, memwrite} !== 4'b1101) begin
            fails++; $display("[TB] FAIL eq_comb: got %b required 1101", {condex, pcsrc, regwrite, memwrite});
        end
        checks++;
        if ({r_pcsrc, r_memwrite} !== 2'b00) begin
            fails++; $display("[TB] FAIL eq_reg_early: got %b required 00", {r_pcsrc, r_memwrite});
        end
        tick();
        checks++;
        if ({r_pcsrc, r_regwrite, r_memwrite} !== 3'b101) begin
            fails++; $display("[TB] FAIL eq_reg_late: got %b required 101", {r_pcsrc, r_regwrite, r_memwrite});
        end
    endtask

    task automatic test_cond_fail();
        drive(0, 1, 0, 2'b11, 4'h1, 4'b1011, 0, 0);
        #1;
        checks++;
        if ({condex, regwrite} !== 2'b00) begin
            fails++; $display("[TB] FAIL ne_blocked: got %b required 00", {condex, regwrite});
        end
        tick();
        checks++;
        if (flags !== 4'b0100) begin
            fails++; $display("[TB] FAIL ne_flags_kept: got %b required 0100", flags);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        drive(0, 0, 0, 2'b11, 4'hE, 4'd1, 0, 0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0, 2'b11, 4'hE, 4'(i + 1), 1, 0);
            tick();
        end
        drive(0, 0, 0, 2'b00, 4'hE, 4'h0, 1, 0);
        tick();
        checks++;
        if ({flags, depth, overflow, underflow} !== {4'b0101, 3'd4, 1'b1, 1'b0}) begin
            fails++; $display("[TB] FAIL overflow: got %b required 010110010", {flags, depth, overflow, underflow});
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 2'b00, 4'hE, 4'h0, 0, 1);
            tick();
            checks++;
            if ({flags, depth} !== {4'(4 - i), 3'(3 - i)}) begin
                fails++; $display("[TB] FAIL pop_order_%0d: got %b/%0d required %b/%0d", i, flags, depth, 4'(4 - i), 3 - i);
            end
        end
    endtask

    task automatic test_underflow();
        do_reset();
        drive(0, 0, 0, 2'b11, 4'hE, 4'b0110, 0, 0);
        tick();
        drive(0, 0, 0, 2'b00, 4'hE, 4'h0, 0, 1);
        tick();
        checks++;
        if ({flags, depth, overflow, underflow} !== {4'b0110, 3'd0, 1'b0, 1'b1}) begin
            fails++; $display("[TB] FAIL underflow: got %b required 011000001", {flags, depth, overflow, underflow});
        end
        drive(0, 0, 0, 2'b00, 4'hE, 4'h0, 1, 0);
        tick();
        drive(0, 0, 0, 2'b00, 4'hE, 4'h0, 0, 1);
        tick();
        checks++;
        if ({flags, depth, underflow} !== {4'b0110, 3'd0, 1'b1}) begin
            fails++; $display("[TB] FAIL underflow_sticky: got %b required 01100001", {flags, depth, underflow});
        end
        do_reset();
        checks++;
        if (underflow !== 1'b0) begin
            fails++; $display("[TB] FAIL underflow_clear: got %b required 0", underflow);
        end
    endtask

    task automatic test_pop_wins();
        do_reset();
        drive(0, 0, 0, 2'b11, 4'hE, 4'b1010, 0, 0);
        tick();
        drive(0, 0, 0, 2'b11, 4'hE, 4'b0011, 1, 0);
        tick();
        checks++;
        if ({flags, depth} !== {4'b0011, 3'd1}) begin
            fails++; $display("[TB] FAIL push_with_write: got %b required 0011001", {flags, depth});
        end
        drive(0, 0, 0, 2'b11, 4'hE, 4'b0101, 0, 1);
        tick();
        checks++;
        if ({flags, depth} !== {4'b1010, 3'd0}) begin
            fails++; $display("[TB] FAIL pop_wins: got %b required 1010000", {flags, depth});
        end
    endtask

    task automatic test_push_pop_both();
        do_reset();
        drive(0, 0, 0, 2'b10, 4'hE, 4'b1100, 1, 1);
        tick();
        drive(0, 0, 0, 2'b01, 4'hE, 4'b0011, 1, 1);
        tick();
        checks++;
        if ({flags, depth, overflow, underflow} !== {4'b1111, 3'd0, 1'b0, 1'b0}) begin
            fails++; $display("[TB] FAIL both_empty: got %b required 111100000", {flags, depth, overflow, underflow});
        end
        drive(0, 0, 0, 2'b00, 4'hE, 4'h0, 1, 0);
        tick();
        drive(0, 0, 0, 2'b11, 4'hE, 4'b0000, 1, 1);
        tick();
        checks++;
        if ({flags, depth, overflow, underflow} !== {4'b0000, 3'd1, 1'b0, 1'b0}) begin
            fails++; $display("[TB] FAIL both_nonempty: got %b required 000000100", {flags, depth, overflow, underflow});
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(0, 0, 0, 2'b00, 4'hE, 4'h0, 0, 1);
        tick();
        drive(1, 0, 0, 2'b11, 4'hE, 4'b0110, 1, 0);
        tick();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({flags, depth, overflow, underflow, r_pcsrc} !== 10'b0) begin
            fails++; $display("[TB] FAIL async_reset: got %b required 0", {flags, depth, overflow, underflow, r_pcsrc});
        end
        model_clear();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc % 60 == 59) do_reset();
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3));
            #1;
            mpass = cond_pass(Cond, mflags);
            exp_comb = {mpass, PCS & mpass, RegW & mpass, MemW & mpass, mreg};
            got_comb = {condex, pcsrc, regwrite, memwrite, r_pcsrc, r_regwrite, r_memwrite};
            checks++;
            if (got_comb !== exp_comb) begin
                fails++; $display("[TB] FAIL rand_enables cyc %0d: got %b required %b", cyc, got_comb, exp_comb);
            end
            tick();
            exp_state = {mflags, 3'(mstack.size()), mover, munder};
            got_state = {flags, depth, overflow, underflow};
            checks++;
            if (got_state !== exp_state || {r_flags, r_depth, r_overflow, r_underflow} !== exp_state) begin
                fails++; $display("[TB] FAIL rand_state cyc %0d: got %b/%b required %b", cyc, got_state,
                                  {r_flags, r_depth, r_overflow, r_underflow}, exp_state);
            end
        end
    endtask

    initial begin
        drive(0, 0, 0, 2'b00, 4'h0, 4'h0, 0, 0);
        model_clear();
        test_reset();
        test_flag_write();
        test_cond_fail();
        test_overflow();
        test_underflow();
        test_pop_wins();
        test_push_pop_both();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
